// File: rtl/rvm_trap_ctrl_pkg.sv
// Shared constants and helpers for the machine-mode trap controller:
// CSR addresses, CSR op encodings, interrupt cause codes and FSM states.
package rvm_trap_ctrl_pkg;

  localparam logic [3:0] CSR_OP_RW = 4'd1;
  localparam logic [3:0] CSR_OP_RS = 4'd2;
  localparam logic [3:0] CSR_OP_RC = 4'd3;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MTIMECMP  = 12'h7c0;
  localparam logic [11:0] CSR_MTIMECMPH = 12'h7c1;
  localparam logic [11:0] CSR_MCYCLE    = 12'hb00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hb02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hb80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hb82;
  localparam logic [11:0] CSR_MHARTID   = 12'hf14;

  localparam logic [4:0] IRQ_CODE_MEI  = 5'd11;
  localparam logic [4:0] IRQ_CODE_MSI  = 5'd3;
  localparam logic [4:0] IRQ_CODE_MTI  = 5'd7;
  localparam logic [4:0] IRQ_CODE_EXT0 = 5'd16;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ENTER  = 2'd1,
    ST_RETURN = 2'd2
  } trap_state_e;

  function automatic logic [31:0] csr_apply(input logic [3:0] op, input logic [31:0] old_val,
                                            input logic [31:0] src);
    logic [31:0] res;
    case (op)
      CSR_OP_RW: res = src;
      CSR_OP_RS: res = old_val | src;
      CSR_OP_RC: res = old_val & ~src;
      default:   res = old_val;
    endcase
    return res;
  endfunction

  // Request index (priority order) to mcause interrupt code.
  function automatic logic [4:0] irq_code(input int idx);
    logic [4:0] res;
    case (idx)
      0:       res = IRQ_CODE_MEI;
      1:       res = IRQ_CODE_MSI;
      2:       res = IRQ_CODE_MTI;
      default: res = IRQ_CODE_EXT0 + 5'(idx - 3);
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rvm_trap_ctrl_irq_prio.sv
// Fixed-priority interrupt encoder: request 0 is highest; returns the
// mcause code of the winning request.
module rvm_trap_ctrl_irq_prio import rvm_trap_ctrl_pkg::*; #(
  parameter int NUM_REQ = 7
) (
  input  logic [NUM_REQ-1:0] req,
  output logic               valid,
  output logic [4:0]         code
);

  // Scan from lowest to highest priority so the highest pending one wins.
  always_comb begin
    valid = 1'b0;
    code  = 5'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      code  = req[i] ? irq_code(i) : code;
      valid = valid | req[i];
    end
  end

endmodule

// File: rtl/rvm_trap_ctrl.sv
// Machine-mode CSR file, interrupt arbitration and trap/MRET sequencing
// unit; issues one-cycle redirects to the PCU.
module rvm_trap_ctrl import rvm_trap_ctrl_pkg::*; #(
  parameter int          NUM_EXT_IRQ = 4,
  parameter int          CNT_WIDTH   = 64,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_01c0,
  parameter bit          VECTORED    = 1'b1,
  parameter logic [31:0] MHARTID     = 32'd0
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   core_stall,
  input  logic [31:0]            pc,
  input  logic                   instr_retired,
  input  logic [3:0]             csr_op,
  input  logic [11:0]            csr_addr,
  input  logic [31:0]            csr_wsrc,
  output logic [31:0]            csr_rdata,
  output logic                   csr_illegal,
  input  logic                   irq_mei,
  input  logic                   irq_msi,
  input  logic [NUM_EXT_IRQ-1:0] ext_irq,
  input  logic                   exc_valid,
  input  logic [3:0]             exc_cause,
  input  logic [31:0]            exc_tval,
  input  logic                   mret,
  output logic                   redirect,
  output logic [31:0]            redirect_pc,
  output logic [31:0]            mepc
);

  localparam int          NUM_REQ    = NUM_EXT_IRQ + 3;
  localparam logic [31:0] MIE_MASK   = 32'h0000_0888 | (((32'd1 << NUM_EXT_IRQ) - 32'd1) << 16);
  localparam logic [31:0] MTVEC_MASK = VECTORED ? 32'hffff_fffd : 32'hffff_fffc;
  localparam logic [63:0] CNT_MASK   = (CNT_WIDTH >= 64) ? 64'hffff_ffff_ffff_ffff
                                                         : ((64'd1 << CNT_WIDTH) - 64'd1);

  trap_state_e state_r, state_next_s;

  logic        mstatus_mie_r, mstatus_mpie_r;
  logic [31:0] mie_r, mtvec_r, mscratch_r, mepc_r, mcause_r, mtval_r;
  logic [63:0] mtimecmp_r, mcycle_r, minstret_r;
  logic        redirect_r;
  logic [31:0] redirect_pc_r;

  logic                mtip_s;
  logic [31:0]         mip_s;
  logic [NUM_REQ-1:0]  req_s;
  logic                irq_valid_s;
  logic [4:0]          irq_code_s;
  logic                csr_known_s, csr_op_valid_s, csr_we_s;
  logic [31:0]         csr_wdata_s;
  logic                take_exc_s, take_irq_s, take_mret_s, trap_s, minstret_inc_s;
  logic [31:0]         trap_base_s, irq_target_s;

  assign mtip_s = (mcycle_r >= mtimecmp_r);

  // Live pending-interrupt view; mip holds no state of its own.
  always_comb begin
    mip_s                      = 32'd0;
    mip_s[3]                   = irq_msi;
    mip_s[7]                   = mtip_s;
    mip_s[11]                  = irq_mei;
    mip_s[16 +: NUM_EXT_IRQ]   = ext_irq;
  end

  assign req_s = {ext_irq & mie_r[16 +: NUM_EXT_IRQ], mtip_s & mie_r[7],
                  irq_msi & mie_r[3], irq_mei & mie_r[11]};

  rvm_trap_ctrl_irq_prio #(.NUM_REQ(NUM_REQ)) u_irq_prio (
    .req   (req_s),
    .valid (irq_valid_s),
    .code  (irq_code_s)
  );

  // CSR read mux; also flags whether the address exists at all.
  always_comb begin
    csr_rdata   = 32'd0;
    csr_known_s = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:   csr_rdata = {19'd0, 2'b11, 3'd0, mstatus_mpie_r, 3'd0, mstatus_mie_r, 3'd0};
      CSR_MIE:       csr_rdata = mie_r;
      CSR_MTVEC:     csr_rdata = mtvec_r;
      CSR_MSCRATCH:  csr_rdata = mscratch_r;
      CSR_MEPC:      csr_rdata = mepc_r;
      CSR_MCAUSE:    csr_rdata = mcause_r;
      CSR_MTVAL:     csr_rdata = mtval_r;
      CSR_MIP:       csr_rdata = mip_s;
      CSR_MTIMECMP:  csr_rdata = mtimecmp_r[31:0];
      CSR_MTIMECMPH: csr_rdata = mtimecmp_r[63:32];
      CSR_MCYCLE:    csr_rdata = mcycle_r[31:0];
      CSR_MCYCLEH:   csr_rdata = mcycle_r[63:32];
      CSR_MINSTRET:  csr_rdata = minstret_r[31:0];
      CSR_MINSTRETH: csr_rdata = minstret_r[63:32];
      CSR_MHARTID:   csr_rdata = MHARTID;
      default:       csr_known_s = 1'b0;
    endcase
  end

  assign csr_op_valid_s = (csr_op == CSR_OP_RW) || (csr_op == CSR_OP_RS) || (csr_op == CSR_OP_RC);
  assign csr_illegal    = csr_op_valid_s && (!csr_known_s || (csr_addr[11:10] == 2'b11));
  assign csr_wdata_s    = csr_apply(csr_op, csr_rdata, csr_wsrc);

  // Next state and trap decisions; only RUN with no stall may decide.
  always_comb begin
    state_next_s = state_r;
    take_exc_s   = 1'b0;
    take_irq_s   = 1'b0;
    take_mret_s  = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (core_stall) begin
          state_next_s = ST_RUN;
        end else if (exc_valid) begin
          take_exc_s   = 1'b1;
          state_next_s = ST_ENTER;
        end else if (mret) begin
          take_mret_s  = 1'b1;
          state_next_s = ST_RETURN;
        end else if (mstatus_mie_r && irq_valid_s) begin
          take_irq_s   = 1'b1;
          state_next_s = ST_ENTER;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_ENTER, ST_RETURN: state_next_s = core_stall ? state_r : ST_RUN;
      default:             state_next_s = ST_RUN;
    endcase
  end

  assign trap_s         = take_exc_s | take_irq_s;
  assign csr_we_s       = (state_r == ST_RUN) && !core_stall && !trap_s && !take_mret_s &&
                          csr_op_valid_s && !csr_illegal;
  assign minstret_inc_s = instr_retired && !core_stall && !trap_s && !take_mret_s;
  assign trap_base_s    = {mtvec_r[31:2], 2'b00};
  assign irq_target_s   = (VECTORED && mtvec_r[0]) ? trap_base_s + {25'd0, irq_code_s, 2'b00}
                                                   : trap_base_s;

  // State register and the registered redirect pulse/target.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r       <= ST_RUN;
      redirect_r    <= 1'b0;
      redirect_pc_r <= 32'd0;
    end else begin
      state_r    <= state_next_s;
      redirect_r <= trap_s | take_mret_s;
      if (take_exc_s)       redirect_pc_r <= trap_base_s;
      else if (take_irq_s)  redirect_pc_r <= irq_target_s;
      else if (take_mret_s) redirect_pc_r <= mepc_r;
      else                  redirect_pc_r <= redirect_pc_r;
    end
  end

  // Trap-touched CSRs: trap entry and MRET take precedence over CSR writes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mstatus_mie_r  <= 1'b0;
      mstatus_mpie_r <= 1'b0;
      mepc_r         <= 32'd0;
      mcause_r       <= 32'd0;
      mtval_r        <= 32'd0;
    end else if (take_exc_s) begin
      mepc_r         <= pc;
      mcause_r       <= {28'd0, exc_cause};
      mtval_r        <= exc_tval;
      mstatus_mpie_r <= mstatus_mie_r;
      mstatus_mie_r  <= 1'b0;
    end else if (take_irq_s) begin
      mepc_r         <= pc;
      mcause_r       <= {1'b1, 26'd0, irq_code_s};
      mtval_r        <= 32'd0;
      mstatus_mpie_r <= mstatus_mie_r;
      mstatus_mie_r  <= 1'b0;
    end else if (take_mret_s) begin
      mstatus_mie_r  <= mstatus_mpie_r;
      mstatus_mpie_r <= 1'b1;
    end else if (csr_we_s) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mstatus_mie_r  <= csr_wdata_s[3];
          mstatus_mpie_r <= csr_wdata_s[7];
        end
        CSR_MEPC:   mepc_r   <= csr_wdata_s;
        CSR_MCAUSE: mcause_r <= csr_wdata_s;
        CSR_MTVAL:  mtval_r  <= csr_wdata_s;
        default: ;
      endcase
    end else begin
      mepc_r <= mepc_r;
    end
  end

  // Software-only CSRs: enables, vector base, scratch and timer compare.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mie_r      <= 32'd0;
      mtvec_r    <= MTVEC_RESET;
      mscratch_r <= 32'd0;
      mtimecmp_r <= 64'hffff_ffff_ffff_ffff;
    end else if (csr_we_s) begin
      case (csr_addr)
        CSR_MIE:       mie_r             <= csr_wdata_s & MIE_MASK;
        CSR_MTVEC:     mtvec_r           <= csr_wdata_s & MTVEC_MASK;
        CSR_MSCRATCH:  mscratch_r        <= csr_wdata_s;
        CSR_MTIMECMP:  mtimecmp_r[31:0]  <= csr_wdata_s;
        CSR_MTIMECMPH: mtimecmp_r[63:32] <= csr_wdata_s;
        default: ;
      endcase
    end else begin
      mie_r <= mie_r;
    end
  end

  // Counters: a write to either half replaces that cycle's increment.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mcycle_r   <= 64'd0;
      minstret_r <= 64'd0;
    end else begin
      if (csr_we_s && csr_addr == CSR_MCYCLE)
        mcycle_r <= {mcycle_r[63:32], csr_wdata_s} & CNT_MASK;
      else if (csr_we_s && csr_addr == CSR_MCYCLEH)
        mcycle_r <= {csr_wdata_s, mcycle_r[31:0]} & CNT_MASK;
      else
        mcycle_r <= (mcycle_r + 64'd1) & CNT_MASK;

      if (csr_we_s && csr_addr == CSR_MINSTRET)
        minstret_r <= {minstret_r[63:32], csr_wdata_s} & CNT_MASK;
      else if (csr_we_s && csr_addr == CSR_MINSTRETH)
        minstret_r <= {csr_wdata_s, minstret_r[31:0]} & CNT_MASK;
      else if (minstret_inc_s)
        minstret_r <= (minstret_r + 64'd1) & CNT_MASK;
      else
        minstret_r <= minstret_r;
    end
  end

  assign redirect    = redirect_r;
  assign redirect_pc = redirect_pc_r;
  assign mepc        = mepc_r;

endmodule
